// File: rtl/dds_pkg.sv
// Shared widths, quadrant encoding and the elaboration-time sine table generator
// for the parallel NCO.
package dds_pkg;

    localparam int LANES_DEF   = 8;
    localparam int PHASE_W_DEF = 32;
    localparam int LUT_AW_DEF  = 10;
    localparam int DATA_W_DEF  = 16;

    typedef enum logic [1:0] {
        QUAD_0 = 2'd0,
        QUAD_1 = 2'd1,
        QUAD_2 = 2'd2,
        QUAD_3 = 2'd3
    } quadrant_e;

    // Half-index offset keeps the table symmetric, so mirroring the address
    // in odd quadrants reproduces the second half of the quarter wave exactly.
    function automatic int sin_quarter(input int i, input int lut_aw, input int data_w);
        real pi;
        real x;
        real amp;
        pi  = 3.14159265358979323846;
        x   = 2.0 * pi * (real'(i) + 0.5) / real'(1 << (lut_aw + 2));
        amp = real'((1 << (data_w - 1)) - 1);
        return $rtoi(amp * $sin(x) + 0.5);
    endfunction

endpackage

// File: rtl/dds_sine_lut.sv
// One output lane: phase truncation, quarter-wave ROM lookup and sign fold,
// three registered stages that all advance on en.
module dds_sine_lut
    import dds_pkg::*;
#(
    parameter int PHASE_W = PHASE_W_DEF,
    parameter int LUT_AW  = LUT_AW_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [PHASE_W-1:0] phase,
    output logic [DATA_W-1:0] sample
);

    localparam int DEPTH = 1 << LUT_AW;

    logic [LUT_AW+1:0] p;
    logic [LUT_AW-1:0] a;
    quadrant_e         quad;

    assign p    = phase[PHASE_W-1 -: LUT_AW+2];
    assign a    = p[LUT_AW-1:0];
    assign quad = quadrant_e'(p[LUT_AW+1:LUT_AW]);

    if (PHASE_W > LUT_AW + 2) begin : g_lsb
        logic unused_lsb;
        assign unused_lsb = ^phase[PHASE_W-LUT_AW-3:0];
    end

    logic [DATA_W-1:0] rom [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        localparam logic [DATA_W-1:0] ROM_VAL = DATA_W'(sin_quarter(i, LUT_AW, DATA_W));
        assign rom[i] = ROM_VAL;
    end

    logic [LUT_AW-1:0] addr_q;
    logic              neg1_q;
    logic [DATA_W-1:0] mag_q;
    logic              neg2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            neg1_q <= 1'b0;
            mag_q  <= '0;
            neg2_q <= 1'b0;
            sample <= '0;
        end else if (en) begin
            addr_q <= (quad == QUAD_1 || quad == QUAD_3) ? ~a : a;
            neg1_q <= (quad == QUAD_2 || quad == QUAD_3);
            mag_q  <= rom[addr_q];
            neg2_q <= neg1_q;
            sample <= neg2_q ? -mag_q : mag_q;
        end
    end

endmodule

// File: rtl/dds_parallel_nco.sv
// Multi-lane NCO: phase accumulator, config holding register and stage 0,
// feeding LANES sine lookups that together form one back-pressurable beat.
module dds_parallel_nco
    import dds_pkg::*;
#(
    parameter int LANES   = LANES_DEF,
    parameter int PHASE_W = PHASE_W_DEF,
    parameter int LUT_AW  = LUT_AW_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2*PHASE_W-1:0]    s_axis_cfg_tdata,
    input  logic                    s_axis_cfg_tuser,
    input  logic                    s_axis_cfg_tvalid,
    output logic                    s_axis_cfg_tready,
    output logic [LANES*DATA_W-1:0] m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready
);

    // Both ports use valid/ready: a transfer happens on a rising edge where
    // valid and ready are both high; the source holds its word until then.
    logic [PHASE_W-1:0] acc;
    logic [PHASE_W-1:0] pinc;
    logic [PHASE_W-1:0] poff;
    logic [PHASE_W-1:0] hold_pinc;
    logic [PHASE_W-1:0] hold_poff;
    logic               hold_clr;
    logic               pending;
    logic [3:0]         stage_v;

    logic adv;
    logic apply;
    logic cfg_hs;

    logic [PHASE_W-1:0]            eff_pinc;
    logic [PHASE_W-1:0]            eff_poff;
    logic [PHASE_W-1:0]            base;
    logic [LANES-1:0][PHASE_W-1:0] phase_d;
    logic [LANES-1:0][PHASE_W-1:0] phase_q;

    assign m_axis_tvalid     = stage_v[3];
    assign adv               = !m_axis_tvalid || m_axis_tready;
    assign s_axis_cfg_tready = !pending && !rst;
    assign cfg_hs            = s_axis_cfg_tvalid && s_axis_cfg_tready;
    assign apply             = pending && adv;

    // The new config takes effect on the very beat it is applied to, so all
    // lanes of that beat see the same pinc/poff.
    always_comb begin
        eff_pinc = apply ? hold_pinc : pinc;
        eff_poff = apply ? hold_poff : poff;
        base     = (apply && hold_clr) ? '0 : acc;
        phase_d  = '0;
        for (int k = 0; k < LANES; k++) begin
            phase_d[k] = base + eff_poff + eff_pinc * PHASE_W'(k);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            pinc      <= '0;
            poff      <= '0;
            hold_pinc <= '0;
            hold_poff <= '0;
            hold_clr  <= 1'b0;
            pending   <= 1'b0;
            stage_v   <= '0;
            phase_q   <= '0;
        end else begin
            if (cfg_hs) begin
                hold_pinc <= s_axis_cfg_tdata[PHASE_W-1:0];
                hold_poff <= s_axis_cfg_tdata[2*PHASE_W-1:PHASE_W];
                hold_clr  <= s_axis_cfg_tuser;
                pending   <= 1'b1;
            end else if (apply) begin
                pending <= 1'b0;
            end
            if (adv) begin
                acc     <= base + eff_pinc * PHASE_W'(LANES);
                pinc    <= eff_pinc;
                poff    <= eff_poff;
                phase_q <= phase_d;
                stage_v <= {stage_v[2:0], 1'b1};
            end
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        dds_sine_lut #(
            .PHASE_W(PHASE_W),
            .LUT_AW (LUT_AW),
            .DATA_W (DATA_W)
        ) u_lut (
            .clk   (clk),
            .rst   (rst),
            .en    (adv),
            .phase (phase_q[k]),
            .sample(m_axis_tdata[DATA_W*k +: DATA_W])
        );
    end

endmodule

// File: tb/tb_dds_parallel_nco.sv
// Bench for dds_parallel_nco: a cycle model predicts every output beat from
// the config stream and back-pressure; predicted beats queue until accepted.
module tb_dds_parallel_nco;

    localparam int LANES   = 8;
    localparam int PHASE_W = 32;
    localparam int LUT_AW  = 10;
    localparam int DATA_W  = 16;
    localparam int W       = LANES * DATA_W;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [2*PHASE_W-1:0] cfg_tdata = '0;
    logic                 cfg_tuser = 1'b0;
    logic                 cfg_tvalid = 1'b0;
    logic                 cfg_tready;
    logic [W-1:0]         tdata;
    logic                 tvalid;
    logic                 tready = 1'b1;

    always #5 clk = ~clk;

    dds_parallel_nco #(
        .LANES  (LANES),
        .PHASE_W(PHASE_W),
        .LUT_AW (LUT_AW),
        .DATA_W (DATA_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .s_axis_cfg_tdata (cfg_tdata),
        .s_axis_cfg_tuser (cfg_tuser),
        .s_axis_cfg_tvalid(cfg_tvalid),
        .s_axis_cfg_tready(cfg_tready),
        .m_axis_tdata     (tdata),
        .m_axis_tvalid    (tvalid),
        .m_axis_tready    (tready)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [W-1:0] exp_q[$];

    logic [PHASE_W-1:0] m_acc  = '0;
    logic [PHASE_W-1:0] m_pinc = '0;
    logic [PHASE_W-1:0] m_poff = '0;
    logic [PHASE_W-1:0] h_pinc = '0;
    logic [PHASE_W-1:0] h_poff = '0;
    logic               h_clr  = 1'b0;
    logic               m_pend = 1'b0;
    logic               last_hs = 1'b0;
    logic               in_rst = 1'b0;
    int                 m_vcnt = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Full-wave reference, evaluated directly without any quadrant folding.
    function automatic logic [DATA_W-1:0] gold(input logic [PHASE_W-1:0] ph);
        int  idx;
        int  r;
        real x;
        real v;
        idx = int'(ph >> (PHASE_W - LUT_AW - 2));
        x   = 2.0 * 3.14159265358979 * (real'(idx) + 0.5) / real'(1 << (LUT_AW + 2));
        v   = real'((1 << (DATA_W - 1)) - 1) * $sin(x);
        if (v >= 0.0) r = $rtoi(v + 0.5);
        else r = -$rtoi(0.5 - v);
        return DATA_W'(r);
    endfunction

    function automatic logic [W-1:0] make_beat(input logic [PHASE_W-1:0] b,
                                               input logic [PHASE_W-1:0] eo,
                                               input logic [PHASE_W-1:0] ep);
        logic [W-1:0] beat;
        beat = '0;
        for (int k = 0; k < LANES; k++) begin
            beat[DATA_W*k +: DATA_W] = gold(b + eo + ep * PHASE_W'(k));
        end
        return beat;
    endfunction

    // Advance the model with the current inputs, clock once, then compare.
    task automatic tick();
        logic               mv;
        logic               adv;
        logic               apply;
        logic               tr;
        logic [PHASE_W-1:0] ep;
        logic [PHASE_W-1:0] eo;
        logic [PHASE_W-1:0] b;
        mv      = (m_vcnt == 4);
        adv     = !mv || tready;
        tr      = !m_pend && !rst;
        last_hs = 1'b0;
        if (rst) begin
            m_acc  = '0;
            m_pinc = '0;
            m_poff = '0;
            m_pend = 1'b0;
            m_vcnt = 0;
            exp_q.delete();
        end else begin
            if (mv && tready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (adv) begin
                apply = m_pend;
                ep = apply ? h_pinc : m_pinc;
                eo = apply ? h_poff : m_poff;
                b  = (apply && h_clr) ? '0 : m_acc;
                exp_q.push_back(make_beat(b, eo, ep));
                m_acc  = b + ep * PHASE_W'(LANES);
                m_pinc = ep;
                m_poff = eo;
                if (apply) m_pend = 1'b0;
                if (m_vcnt < 4) m_vcnt++;
            end
            if (cfg_tvalid && tr) begin
                h_pinc  = cfg_tdata[PHASE_W-1:0];
                h_poff  = cfg_tdata[2*PHASE_W-1:PHASE_W];
                h_clr   = cfg_tuser;
                m_pend  = 1'b1;
                last_hs = 1'b1;
            end
        end
        in_rst = rst;
        @(posedge clk);
        #1;
        check("cfg_tready", W'(cfg_tready), W'(!m_pend && !rst));
        check("tvalid", W'(tvalid), W'(m_vcnt == 4));
        if (in_rst) check("rst_tdata", tdata, '0);
        else if (m_vcnt == 4 && exp_q.size() > 0) check("tdata", tdata, exp_q[0]);
    endtask

    task automatic send_cfg(input logic [PHASE_W-1:0] pinc, input logic [PHASE_W-1:0] poff,
                            input logic clr);
        logic ok;
        ok         = 1'b0;
        cfg_tdata  = {poff, pinc};
        cfg_tuser  = clr;
        cfg_tvalid = 1'b1;
        for (int i = 0; i < 32; i++) begin
            tick();
            if (last_hs) begin
                ok = 1'b1;
                break;
            end
        end
        cfg_tvalid = 1'b0;
        check("cfg_accept", W'(ok), W'(1));
    endtask

    logic [W-1:0] flat25;
    logic [W-1:0] quad_pat;

    initial begin
        for (int k = 0; k < LANES; k++) begin
            flat25[DATA_W*k +: DATA_W] = 16'd25;
            case (k % 4)
                0: quad_pat[DATA_W*k +: DATA_W] = 16'd25;
                1: quad_pat[DATA_W*k +: DATA_W] = 16'd32767;
                2: quad_pat[DATA_W*k +: DATA_W] = 16'hFFE7;
                default: quad_pat[DATA_W*k +: DATA_W] = 16'h8001;
            endcase
        end

        // reset release, no config
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        check("c0_cfg_tready", W'(cfg_tready), W'(1));
        repeat (3) tick();
        check("c3_tvalid_low", W'(tvalid), W'(0));
        tick();
        check("c4_tvalid", W'(tvalid), W'(1));
        check("c4_lanes", tdata, flat25);
        repeat (4) tick();

        // quarter-turn per lane with accumulator clear
        send_cfg(32'h4000_0000, 32'h0, 1'b1);
        repeat (6) tick();
        check("quad_beat", tdata, quad_pat);
        tick();
        check("quad_next", tdata, quad_pat);

        // frequency change mid-stream without clear
        send_cfg(32'h0100_0000, 32'h0, 1'b1);
        repeat (10) tick();
        send_cfg(32'h0200_0000, 32'h0, 1'b0);
        repeat (10) tick();

        // ten-cycle downstream stall
        tready = 1'b0;
        repeat (10) tick();
        tready = 1'b1;
        repeat (8) tick();

        // random config and random back-pressure
        send_cfg($urandom, $urandom, 1'b0);
        for (int i = 0; i < 40; i++) begin
            tready = ($urandom_range(0, 3) != 0);
            tick();
        end
        tready = 1'b1;
        repeat (4) tick();

        // two back-to-back configs while the output is stalled
        tready = 1'b0;
        tick();
        cfg_tdata  = {32'h1234_5678, 32'h0080_0000};
        cfg_tuser  = 1'b0;
        cfg_tvalid = 1'b1;
        tick();
        check("b2b_first_taken", W'(cfg_tready), W'(0));
        cfg_tdata = {32'h0, 32'h0300_0000};
        repeat (5) begin
            tick();
            check("b2b_stalled", W'(cfg_tready), W'(0));
        end
        tready = 1'b1;
        tick();
        check("b2b_ready_again", W'(cfg_tready), W'(1));
        tick();
        check("b2b_second_taken", W'(cfg_tready), W'(0));
        cfg_tvalid = 1'b0;
        repeat (8) tick();

        // reset with a pending config and a full pipeline
        tready = 1'b0;
        repeat (2) tick();
        send_cfg($urandom, $urandom, 1'b1);
        rst = 1'b1;
        tick();
        check("mid_rst_tvalid", W'(tvalid), W'(0));
        check("mid_rst_tdata", tdata, '0);
        check("mid_rst_tready", W'(cfg_tready), W'(0));
        rst    = 1'b0;
        tready = 1'b1;
        #1;
        check("rerel_c0_tready", W'(cfg_tready), W'(1));
        repeat (4) tick();
        check("rerel_c4_tvalid", W'(tvalid), W'(1));
        check("rerel_c4_lanes", tdata, flat25);
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dds_parallel_nco.md
# dds_parallel_nco

Parametrised multi-lane numerically controlled oscillator with no vendor IP. Every output beat carries LANES consecutive sine samples of one continuous waveform. Frequency and phase offset come in as an AXI-Stream config word and are applied coherently to all lanes on a single beat, with optional phase-accumulator clear. It sits between the frequency-control logic and the DAC lane interface, and its full-rate output is back-pressurable.

## Interface
- LANES, 8: samples per output beat; must be ≥1.
- PHASE_W, 32: phase accumulator and pinc/poff width.
- LUT_AW, 10: quarter-wave ROM address width; LUT_AW+2 ≤ PHASE_W.
- DATA_W, 16: signed sample width.
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- s_axis_cfg_tdata  in  2*PHASE_W  config word: {poff[PHASE_W-1:0], pinc[PHASE_W-1:0]}.
- s_axis_cfg_tuser  in  1  1 = clear the phase accumulator when this config is applied.
- s_axis_cfg_tvalid  in  1  config valid.
- s_axis_cfg_tready  out  1  config holding register is empty.
- m_axis_tdata  out  LANES*DATA_W  lane k occupies [DATA_W*(k+1)-1:DATA_W*k]; lane 0 is the earliest sample.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  downstream accept.

## Operation
- Reset values, while rst=1 and registered:
  - m_axis_tdata=0, m_axis_tvalid=0, s_axis_cfg_tready=0.
  - acc=0, pinc=0, poff=0, pending=0, all stage valids=0.
- Reset applied mid-operation discards the pipeline and any pending config.
- Advance enable: `adv = !m_axis_tvalid | m_axis_tready`. All pipeline stages and acc update only when adv=1.
- When m_axis_tvalid=1 and m_axis_tready=0:
  - all stages freeze and m_axis_tdata holds;
  - no samples are lost, because the output is sample-indexed, not time-indexed.
- Config path:
  - Handshake (tvalid & tready) captures the word into the holding register and sets pending.
  - tready = !pending && !rst.
  - Pending config is applied on the first adv cycle strictly after the handshake cycle, then pending clears.
  - While pending, further configs are stalled.
- Stage 0 (phase), on an adv cycle:
  - base = (apply & tuser) ? 0 : acc.
  - phase_k = base + poff + k*pinc for k = 0..LANES-1, all mod 2^PHASE_W.
  - acc ← base + LANES*pinc, mod 2^PHASE_W.
  - pinc/poff are the new values on the apply cycle.
- Stage 1 (truncate):
  - p = phase_k[PHASE_W-1 -: LUT_AW+2]; q = p[LUT_AW+1:LUT_AW]; a = p[LUT_AW-1:0].
  - addr = q[0] ? ~a : a; neg = q[1].
- Stage 2 (ROM): rom[i] = round((2^(DATA_W-1)-1)·sin(2π(i+0.5)/2^(LUT_AW+2))). Half-index offset makes the quarter-wave fold exact.
- Stage 3 (sign fold): out = neg ? -rom : rom, registered into m_axis_tdata.
- Stage valids: each stage valid shifts in 1 on every adv cycle. The source is free-running, so there are no bubbles after fill.

## Timing
- Pipeline: 4 register stages from the acc/config-apply cycle to m_axis_tdata.
- Start-up: rst falls before cycle 0, so cycle 0 is the first cycle with rst=0.
  - s_axis_cfg_tready=1 in cycle 0.
  - First m_axis_tvalid=1 in cycle 4, with pinc=0, so all lanes = rom[0].
- Config latency, with m_axis_tready held 1:
  - handshake in cycle T → applied in cycle T+1 → first beat with the new config visible in cycle T+5;
  - s_axis_cfg_tready low in cycle T+1, high again in cycle T+2.
- Stall: each stall cycle delays application and output by one cycle. Beat contents are unchanged.
- Coherence: one beat never mixes old and new pinc/poff.

## Structure
- Package dds_pkg:
  - sample/phase width localparams;
  - quadrant typedef;
  - constant function sin_quarter(i, LUT_AW, DATA_W) for ROM init, using real math at elaboration.
- Sub-module dds_sine_lut covers stages 1–3 for one lane and is instantiated LANES times.
  - It has its own enable and keeps the same 3-cycle latency.
  - The top holds the acc, config, valid logic and stage 0.

## Test plan
Parameters for all scenarios: LANES=8, PHASE_W=32, LUT_AW=10, DATA_W=16.
- Reset release, no config:
  - s_axis_cfg_tready=1 in cycle 0.
  - From cycle 4, m_axis_tvalid=1 and every lane = +25.
- Config pinc=0x4000_0000, poff=0, tuser=1:
  - Lanes 0..7 = +25, +32767, −25, −32767 repeated.
  - The next beat is identical.
- pinc=0x0100_0000, then a new config pinc=0x0200_0000 with tuser=0 mid-stream:
  - The first changed beat's lane 0 phase continues from the old acc.
  - Lane steps are 0x0200_0000 within that beat; no beat mixes old and new pinc.
- m_axis_tready held 0 for 10 cycles during streaming:
  - tdata stays stable throughout.
  - After release, the sample sequence continues with no gap or duplicate. Check it against a golden phase model.
- Two back-to-back cfg tvalid pulses while m_axis_tready=0:
  - The first is accepted; tready stays 0 until the stall ends and the first config applies.
  - The second is accepted one cycle later.
- Assert rst while a config is pending and the pipeline is full:
  - The next cycle shows tvalid=0, tdata=0 and tready=0.
  - After release, the cycle-0 behaviour matches the reset-release scenario (old config discarded).
